// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main control FSM for the multicycle MIPS-subset test processor. It drives the
// per-cycle enables (PC, IR, register file, memory), the datapath mux selects
// and the ALU control, and it stalls on the memory ready handshake.
//
// Build option: define MULTICYCLE_BNE_EN to decode op 000101 (bne) into the
// BNEEX state (encoding 12). Without it, bne is treated as an illegal opcode.
module multicycle_ctrl #(
  parameter int STATE_W = 4,
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_write,
  output logic               mem_req,
  output logic               iord,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
`ifdef MULTICYCLE_BNE_EN
    ,
    BNEEX   = 4'd12
`endif
  } state_t;

  // Abstract ALU request; NONE means the ALU is not used and its control reads 0.
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'd0,
    ALUOP_ADD   = 2'd1,
    ALUOP_SUB   = 2'd2,
    ALUOP_FUNCT = 2'd3
  } aluop_t;

  // Opcodes, as seen in instr[31:26]
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
`ifdef MULTICYCLE_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

  // R-type function codes, as seen in instr[5:0]
  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state;
  state_t state_nxt;
  aluop_t aluop;

  // Map the abstract ALU request (and funct for R-type) onto the ALU opcode.
  // Unknown funct codes fall back to add so the datapath stays well defined.
  function automatic logic [2:0] alu_decode(input aluop_t req,
                                            input logic [FUNCT_W-1:0] fn);
    logic [2:0] code;
    code = 3'b000;
    case (req)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (fn)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: code = ALU_ADD;
        endcase
      end
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  // State register; reset pulls the FSM back to FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Moore outputs; everything is forced low while reset is
  // asserted so an interrupted memory access drops its request in that cycle
  always_comb begin
    state_nxt  = FETCH;
    aluop      = ALUOP_NONE;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    illegal    = 1'b0;

    if (!reset) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          aluop     = ALUOP_ADD;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_en     = 1'b1;
            state_nxt = DECODE;
          end else begin
            state_nxt = FETCH;
          end
        end

        DECODE: begin
          alu_src_b = 2'b11;
          aluop     = ALUOP_ADD;
          case (op)
            OP_LW, OP_SW: state_nxt = MEMADR;
            OP_RTYPE:     state_nxt = RTYPEEX;
            OP_BEQ:       state_nxt = BEQEX;
            OP_ADDI:      state_nxt = ADDIEX;
            OP_J:         state_nxt = JEX;
`ifdef MULTICYCLE_BNE_EN
            OP_BNE:       state_nxt = BNEEX;
`endif
            default: begin
              illegal   = 1'b1;
              state_nxt = FETCH;
            end
          endcase
        end

        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluop     = ALUOP_ADD;
          if (op == OP_LW) begin
            state_nxt = MEMRD;
          end else begin
            state_nxt = MEMWR;
          end
        end

        MEMRD: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          state_nxt = mem_ready ? MEMWB : MEMRD;
        end

        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_nxt  = FETCH;
        end

        MEMWR: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          mem_write = mem_ready;
          state_nxt = mem_ready ? FETCH : MEMWR;
        end

        RTYPEEX: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_FUNCT;
          state_nxt = RTYPEWB;
        end

        RTYPEWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_nxt = FETCH;
        end

        BEQEX: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_SUB;
          pc_src    = 2'b01;
          pc_en     = zero;
          state_nxt = FETCH;
        end

`ifdef MULTICYCLE_BNE_EN
        BNEEX: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_SUB;
          pc_src    = 2'b01;
          pc_en     = ~zero;
          state_nxt = FETCH;
        end
`endif

        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluop     = ALUOP_ADD;
          state_nxt = ADDIWB;
        end

        ADDIWB: begin
          reg_write = 1'b1;
          state_nxt = FETCH;
        end

        JEX: begin
          pc_src    = 2'b10;
          pc_en     = 1'b1;
          state_nxt = FETCH;
        end

        // Unused encodings recover to FETCH on the next edge
        default: state_nxt = FETCH;
      endcase
    end
  end

  // ALU control follows the abstract request chosen above
  always_comb begin
    alu_control = alu_decode(aluop, funct);
  end

  assign state_o = STATE_W'(state);

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle test processor (MIPS-subset ISA).
- Sits directly upstream of the enable flip-flops: it generates the per-cycle enables for PC, IR, register file and memory, plus the datapath mux selects and the ALU control.
- Stalls on a memory ready handshake.
- One instruction takes 3–5 cycles plus any memory wait cycles.

Parameters:
- STATE_W, 4, width of the state_o debug output.
- OP_W, 6, opcode width.
- FUNCT_W, 6, funct field width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; forces the FSM to FETCH.
- op  in  OP_W  instr[31:26], taken from the IR register.
- funct  in  FUNCT_W  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_en  out  1  PC register enable.
- ir_write  out  1  IR register enable.
- reg_write  out  1  register-file write enable.
- mem_write  out  1  memory write strobe.
- mem_req  out  1  memory access request.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- mem_to_reg  out  1  write-back data select: 1 = Data register.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm shifted left by 2.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  out  3  ALU operation code.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- state_o  out  STATE_W  current state encoding (debug).

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are unreachable; if entered, go to FETCH next cycle.
- Reset: state forced to FETCH immediately (async) and held while reset is high.
- Outputs are combinational from state (Moore). pc_en and illegal also depend on inputs.
- Any output not listed for a state is 0.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=add, pc_src=00.
  - If mem_ready: ir_write=1, pc_en=1, go to DECODE. Otherwise hold, with ir_write=0 and pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, aluop=add. Next state by op:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 → RTYPEEX.
  - 000100 → BEQEX.
  - 001000 → ADDIEX.
  - 000010 → JEX.
  - Any other op → FETCH, with illegal=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, aluop=add. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=mem_ready. Hold until mem_ready, then → FETCH.
- RTYPEEX: alu_src_a=1, alu_src_b=00, aluop=funct → RTYPEWB.
- RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, aluop=sub, pc_src=01, pc_en=zero → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, aluop=add → ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- JEX: pc_src=10, pc_en=1 → FETCH.
- alu_control:
  - aluop add → 010; aluop sub → 110.
  - aluop funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, anything else → 010.
- Memory handshake: mem_ready is ignored outside FETCH, MEMRD and MEMWR. mem_req stays high continuously while waiting.
- Reset during a memory wait: mem_req drops the same cycle (async), and no write is issued.

Optional Feature:
- Macro MULTICYCLE_BNE_EN.
- Defined: op 000101 (bne) decodes to a BNEEX state, encoding 12. BNEEX drives the same outputs as BEQEX except pc_en = ~zero, then → FETCH.
- Undefined: 000101 is illegal (DECODE → FETCH with an illegal pulse), and code 12 is unreachable.

Test Plan:
- Reset held 3 cycles with mem_ready=1 → state_o=0 throughout. After release: FETCH, then ir_write=1 and pc_en=1 in the first cycle, then state_o=1.
- lw (op=100011), mem_ready=1 except 2 wait cycles in MEMRD → state sequence 0,1,2,3,3,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4.
- sw (op=101011), mem_ready=0 for 1 cycle in MEMWR → mem_write=0 in the first MEMWR cycle and 1 in the second, with mem_req=1 in both; reg_write never asserted.
- R-type (op=0) with funct 100010 and 101010 → RTYPEEX alu_control=110 and 111 respectively; RTYPEWB has reg_dst=1 and reg_write=1.
- beq with zero=1, then zero=0 → pc_en=1 (with pc_src=01) in BEQEX for the first, pc_en=0 for the second; j (op=000010) → JEX with pc_src=10 and pc_en=1.
- op=111111, and op=000101 with the macro off → DECODE pulses illegal=1 and the next state is FETCH. With MULTICYCLE_BNE_EN defined, op=000101 and zero=0 → state_o=12 and pc_en=1.
